// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and forwarding controller for a 5-stage pipeline: shadows EX/MEM/WB destination
// flow, resolves load-use stalls and redirects, and selects ALU operand forwarding.
module pipeline_hazard_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_reg_write,
    input  logic             id_is_load,
    input  logic             ex_redirect,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    logic             ex_valid_q, ex_reg_write_q, ex_is_load_q;
    logic             ex_use_rs1_q, ex_use_rs2_q;
    logic [4:0]       ex_rd_q, ex_rs1_q, ex_rs2_q;
    logic             mem_valid_q, mem_reg_write_q, mem_is_load_q;
    logic [4:0]       mem_rd_q;
    logic             wb_valid_q, wb_reg_write_q, wb_is_load_q;
    logic [4:0]       wb_rd_q;
    logic [CNT_W-1:0] stall_count_q, flush_count_q;
    logic             lu;

    always_comb begin
        lu = ex_valid_q & ex_is_load_q & ex_reg_write_q & (ex_rd_q != 5'd0) & id_valid &
             ((id_use_rs1 & (id_rs1 == ex_rd_q)) | (id_use_rs2 & (id_rs2 == ex_rd_q)));
    end

    // Redirect squashes the younger instructions, so a coincident load-use stall is moot.
    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        if (reset) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (ex_redirect) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (lu) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    function automatic logic [1:0] fwd_sel(
        input logic       ex_v,
        input logic       use_src,
        input logic [4:0] rs,
        input logic       mem_v,
        input logic       mem_w,
        input logic [4:0] mem_rd,
        input logic       wb_v,
        input logic       wb_w,
        input logic [4:0] wb_rd
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (ex_v && use_src) begin
            if (mem_v && mem_w && (mem_rd != 5'd0) && (mem_rd == rs)) begin
                sel = 2'b10;
            end else if (wb_v && wb_w && (wb_rd != 5'd0) && (wb_rd == rs)) begin
                sel = 2'b01;
            end
        end
        return sel;
    endfunction

    always_comb begin
        fwd_a = fwd_sel(ex_valid_q, ex_use_rs1_q, ex_rs1_q, mem_valid_q, mem_reg_write_q,
                        mem_rd_q, wb_valid_q, wb_reg_write_q, wb_rd_q);
        fwd_b = fwd_sel(ex_valid_q, ex_use_rs2_q, ex_rs2_q, mem_valid_q, mem_reg_write_q,
                        mem_rd_q, wb_valid_q, wb_reg_write_q, wb_rd_q);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ex_valid_q      <= 1'b0;
            ex_reg_write_q  <= 1'b0;
            ex_is_load_q    <= 1'b0;
            ex_use_rs1_q    <= 1'b0;
            ex_use_rs2_q    <= 1'b0;
            ex_rd_q         <= 5'd0;
            ex_rs1_q        <= 5'd0;
            ex_rs2_q        <= 5'd0;
            mem_valid_q     <= 1'b0;
            mem_reg_write_q <= 1'b0;
            mem_is_load_q   <= 1'b0;
            mem_rd_q        <= 5'd0;
            wb_valid_q      <= 1'b0;
            wb_reg_write_q  <= 1'b0;
            wb_is_load_q    <= 1'b0;
            wb_rd_q         <= 5'd0;
            stall_count_q   <= '0;
            flush_count_q   <= '0;
        end else begin
            wb_valid_q      <= mem_valid_q;
            wb_reg_write_q  <= mem_reg_write_q;
            wb_is_load_q    <= mem_is_load_q;
            wb_rd_q         <= mem_rd_q;
            mem_valid_q     <= ex_valid_q;
            mem_reg_write_q <= ex_reg_write_q;
            mem_is_load_q   <= ex_is_load_q;
            mem_rd_q        <= ex_rd_q;
            ex_valid_q      <= id_valid & ~idex_bubble;
            ex_reg_write_q  <= id_reg_write;
            ex_is_load_q    <= id_is_load;
            ex_use_rs1_q    <= id_use_rs1;
            ex_use_rs2_q    <= id_use_rs2;
            ex_rd_q         <= id_rd;
            ex_rs1_q        <= id_rs1;
            ex_rs2_q        <= id_rs2;
            if (lu && !ex_redirect && (stall_count_q != {CNT_W{1'b1}})) begin
                stall_count_q <= stall_count_q + CNT_W'(1);
            end
            if (ex_redirect && (flush_count_q != {CNT_W{1'b1}})) begin
                flush_count_q <= flush_count_q + CNT_W'(1);
            end
        end
    end

    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and forwarding controller for the 5-stage pipelined `processor` (IF/ID/EX/MEM/WB). It shadows the destination-register flow of the EX, MEM and WB stages in its own stage registers. From that state it generates PC and IF/ID enables, bubble and flush controls, and ALU operand forwarding selects. It resolves load-use stalls and taken-branch/jump redirects, and keeps saturating stall and flush event counters for test visibility.

## Interface
Parameters:
- `CNT_W`, default 16: width of event counters.

Ports:
- `clock`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `id_valid`  in  1  ID stage holds a real instruction (not a bubble).
- `id_rs1`, `id_rs2`  in  5 each  source registers of the ID instruction.
- `id_use_rs1`, `id_use_rs2`  in  1 each  ID instruction reads that source.
- `id_rd`  in  5  destination register of the ID instruction.
- `id_reg_write`  in  1  ID instruction writes `id_rd`.
- `id_is_load`  in  1  ID instruction is a load.
- `ex_redirect`  in  1  the branch/jump in EX is taken this cycle.
- `pc_en`  out  1  PC register update enable.
- `ifid_en`  out  1  IF/ID register load enable.
- `ifid_flush`  out  1  IF/ID loads a NOP next edge.
- `idex_bubble`  out  1  ID/EX loads a bubble next edge.
- `fwd_a`, `fwd_b`  out  2 each  EX operand select: 00 register file, 01 WB result, 10 MEM ALU result.
- `stall_count`  out  CNT_W  load-use stall cycles.
- `flush_count`  out  CNT_W  redirect events.

## Operation
- Internal stage records EX, MEM and WB. Each record holds: valid, rd, reg_write, is_load. The EX record also holds rs1, rs2, use_rs1 and use_rs2.
- Load-use hazard (`lu`), combinational:
  - Condition: EX.valid & EX.is_load & EX.reg_write & EX.rd≠0 & id_valid, and
  - either (id_use_rs1 & id_rs1==EX.rd) or (id_use_rs2 & id_rs2==EX.rd).
- Redirect takes priority over `lu`:
  - `ex_redirect`=1: pc_en=1, ifid_en=1, ifid_flush=1, idex_bubble=1; `lu` ignored.
  - Otherwise `lu`=1: pc_en=0, ifid_en=0, ifid_flush=0, idex_bubble=1.
  - Otherwise: pc_en=1, ifid_en=1, ifid_flush=0, idex_bubble=0.
- `reset`=1 forces pc_en=0, ifid_en=0, ifid_flush=1, idex_bubble=1.
- Stage advance every edge, never held:
  - WB←MEM; MEM←EX.
  - EX←ID fields, with valid=id_valid & ~idex_bubble.
- Forwarding for `fwd_a` (rs1), combinational from EX/MEM/WB records; `fwd_b` identical using rs2:
  - 10 if EX.use_rs1 & MEM.valid & MEM.reg_write & MEM.rd≠0 & MEM.rd==EX.rs1.
  - else 01 if the same condition holds on the WB record.
  - else 00.
  - MEM has priority over WB. x0 is never forwarded.
  - An invalid EX record gives 00.
- Counters saturate at all-ones and never wrap:
  - `stall_count` increments on each cycle with `lu` & ~ex_redirect & ~reset.
  - `flush_count` increments on each cycle with `ex_redirect` & ~reset.

## Timing
- All control outputs are combinational from the current state and ID/EX inputs, with zero-cycle latency. No combinational path exists from `ex_redirect` to `fwd_*`.
- Load-use penalty is exactly 1 cycle. The next cycle's EX is a bubble, so `lu` deasserts and the load is in MEM. The following cycle the dependent instruction reaches EX, with the load in WB and fwd=01.
- Redirect penalty is 2 cycles: the IF/ID and ID/EX contents are squashed.
- Reset is synchronous. The edge with `reset`=1 clears all valid bits and both counters to 0.
- Outputs the cycle after reset deasserts: pc_en=1, ifid_en=1, ifid_flush=0, idex_bubble=0, fwd=00.
- Reset mid-stall or mid-redirect discards all pending hazards.
- Register-file same-cycle write/read (WB→ID) is out of scope; the register file bypasses it internally.

## Test plan
- Back-to-back ALU RAW: ADD x3,x1,x2 then SUB x4,x3,x2. When SUB is in EX, fwd_a=10 and fwd_b=00. With one NOP between them, fwd_a=01.
- Double hazard: two writers to x3 in MEM and WB, consumer rs1=x3 in EX -> fwd_a=10 (MEM wins).
- Load-use: LW x5,0(x1) then ADD x6,x5,x5 -> exactly one cycle with pc_en=0, ifid_en=0, idex_bubble=1, stall_count=1. On the next cycle ADD is in EX with fwd_a=fwd_b=01.
- x0 and unused sources:
  - LW x0 followed by a consumer of x0 -> no stall, fwd=00.
  - I-type with id_use_rs2=0 and id_rs2==EX.rd of a load -> no stall.
- Redirect during load-use: `lu` and `ex_redirect` asserted together -> pc_en=1, ifid_flush=1, idex_bubble=1, flush_count+1, stall_count unchanged.
- Reset and saturation:
  - Assert `reset` mid-stall -> next cycle all valid bits clear, counters 0, `lu`=0.
  - Preload via CNT_W=2 and stall 5 times -> stall_count holds at 3.
